cnt_acc: RTL and testbench

CNT_ACC -- requirements
Module: cnt_acc

---
 rtl/cnt_acc_pkg.sv | 24 ++
 rtl/cnt_acc_popcnt.sv | 17 +
 rtl/cnt_acc.sv | 153 +++++++++++++++
 tb/tb_cnt_acc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_acc_pkg.sv
// Shared constants for the channel popcount accumulator: register map,
// CTRL bit positions, bus transfer encoding and the bus FSM state type.
package cnt_acc_pkg;

  localparam logic [31:0] ADDR_CTRL     = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS   = 32'h0000_0004;
  localparam logic [31:0] ADDR_ACC_BASE = 32'h0000_0010;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_SAT_BIT = 1;
  localparam int CTRL_CLR_BIT = 2;

  localparam logic [1:0] TRANS_REQ = 2'b10;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

  function automatic logic [31:0] acc_addr(input int n);
    return ADDR_ACC_BASE + 32'(4 * n);
  endfunction

endpackage

// File: rtl/cnt_acc_popcnt.sv
// Combinational population count of one sample word.
module cnt_acc_popcnt #(
  parameter  int data_width_p = 10,
  localparam int cnt_width_p  = $clog2(data_width_p + 1)
) (
  input  logic [data_width_p-1:0] data_i,
  output logic [cnt_width_p-1:0]  cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < data_width_p; i++) begin
      cnt_o = cnt_o + cnt_width_p'(data_i[i]);
    end
  end

endmodule

// File: rtl/cnt_acc.sv
// Per-channel popcount accumulator with a register bus for control and readback.
//   state    | meaning
//   BUS_IDLE | waiting for a request; a request is captured and decoded here
//   BUS_RESP | ready strobe with the captured response; new requests ignored
module cnt_acc
  import cnt_acc_pkg::*;
#(
  parameter  int data_width_p = 10,
  parameter  int chan_p       = 4,
  parameter  int acc_width_p  = 16,
  localparam int cnt_width_p  = $clog2(data_width_p + 1)
) (
  input  logic                      main_clk_i,
  input  logic                      main_rst_i,
  input  logic                      key_valid_i,
  output logic                      key_accept_o,
  input  logic [data_width_p-1:0]   key_data_i,
  input  logic [$clog2(chan_p)-1:0] key_chan_i,
  output logic [cnt_width_p-1:0]    cnt_o,
  output logic                      cnt_valid_o,
  input  logic [1:0]                bus_trans_i,
  input  logic [31:0]               bus_addr_i,
  input  logic                      bus_write_i,
  input  logic [31:0]               bus_wdata_i,
  output logic                      bus_ready_o,
  output logic                      bus_resp_o,
  output logic [31:0]               bus_rdata_o,
  output logic [chan_p-1:0]         ovf_o
);

  bus_state_e state_q, state_d;

  logic                   ctrl_en_q, ctrl_sat_q, clr_pend_q;
  logic [acc_width_p-1:0] acc_q [chan_p];
  logic [acc_width_p-1:0] acc_d [chan_p];
  logic [acc_width_p:0]   sum;
  logic [chan_p-1:0]      ovf_q, ovf_d;
  logic [cnt_width_p-1:0] pop, cnt_q;
  logic                   cnt_valid_q;
  logic                   resp_err_q;
  logic [31:0]            resp_rdata_q;

  logic                   capture, wr_en, xfer;
  logic                   hit_ctrl, hit_status, mapped;
  logic [chan_p-1:0]      hit_acc;
  logic [31:0]            rd_data;
  logic                   unused_wdata;

  cnt_acc_popcnt #(.data_width_p(data_width_p)) u_popcnt (
    .data_i (key_data_i),
    .cnt_o  (pop)
  );

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) state_q <= BUS_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUS_IDLE: if (bus_trans_i == TRANS_REQ) state_d = BUS_RESP;
      BUS_RESP: state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  assign capture      = (state_q == BUS_IDLE) && (bus_trans_i == TRANS_REQ);
  assign wr_en        = capture && bus_write_i;
  assign key_accept_o = ctrl_en_q && !clr_pend_q;
  assign xfer         = key_valid_i && key_accept_o;
  assign unused_wdata = ^bus_wdata_i;

  // Exact-address match also rejects any non-word-aligned access.
  always_comb begin
    hit_ctrl   = (bus_addr_i == ADDR_CTRL);
    hit_status = (bus_addr_i == ADDR_STATUS);
    hit_acc    = '0;
    rd_data    = '0;
    for (int n = 0; n < chan_p; n++) hit_acc[n] = (bus_addr_i == acc_addr(n));
    mapped = hit_ctrl || hit_status || (|hit_acc);
    if (hit_ctrl) begin
      rd_data[CTRL_EN_BIT]  = ctrl_en_q;
      rd_data[CTRL_SAT_BIT] = ctrl_sat_q;
    end
    if (hit_status) rd_data[chan_p-1:0] = ovf_q;
    for (int n = 0; n < chan_p; n++) begin
      if (hit_acc[n]) rd_data[acc_width_p-1:0] = acc_q[n];
    end
  end

  // Priority per channel: clear, then bus write, then stream increment.
  always_comb begin
    sum   = '0;
    ovf_d = ovf_q;
    if (wr_en && hit_status) ovf_d = ovf_q & ~bus_wdata_i[chan_p-1:0];
    for (int n = 0; n < chan_p; n++) begin
      acc_d[n] = acc_q[n];
      sum      = {1'b0, acc_q[n]} + (acc_width_p + 1)'(pop);
      if (wr_en && hit_acc[n]) begin
        acc_d[n] = bus_wdata_i[acc_width_p-1:0];
      end else if (xfer && (32'(key_chan_i) == 32'(n))) begin
        if (sum[acc_width_p]) begin
          ovf_d[n] = 1'b1;
          acc_d[n] = ctrl_sat_q ? '1 : sum[acc_width_p-1:0];
        end else begin
          acc_d[n] = sum[acc_width_p-1:0];
        end
      end
    end
    if (clr_pend_q) begin
      ovf_d = '0;
      for (int n = 0; n < chan_p; n++) acc_d[n] = '0;
    end
  end

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      ctrl_en_q    <= 1'b0;
      ctrl_sat_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
      ovf_q        <= '0;
      cnt_q        <= '0;
      cnt_valid_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      for (int n = 0; n < chan_p; n++) acc_q[n] <= '0;
    end else begin
      clr_pend_q <= 1'b0;
      if (wr_en && hit_ctrl) begin
        ctrl_en_q  <= bus_wdata_i[CTRL_EN_BIT];
        ctrl_sat_q <= bus_wdata_i[CTRL_SAT_BIT];
        clr_pend_q <= bus_wdata_i[CTRL_CLR_BIT];
      end
      for (int n = 0; n < chan_p; n++) acc_q[n] <= acc_d[n];
      ovf_q       <= ovf_d;
      cnt_valid_q <= xfer;
      if (xfer) cnt_q <= pop;
      if (capture) begin
        resp_err_q   <= !mapped;
        resp_rdata_q <= bus_write_i ? '0 : rd_data;
      end
    end
  end

  assign bus_ready_o = (state_q == BUS_RESP);
  assign bus_resp_o  = bus_ready_o && resp_err_q;
  assign bus_rdata_o = bus_ready_o ? resp_rdata_q : '0;
  assign cnt_o       = cnt_q;
  assign cnt_valid_o = cnt_valid_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_cnt_acc.sv
// Self-checking bench for cnt_acc: cycle model compared every cycle plus
// directed scenarios with hand-computed register values.
module tb_cnt_acc;

  localparam int CH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic        key_accept;
  logic [9:0]  key_data = '0;
  logic [1:0]  key_chan = '0;
  logic [3:0]  cnt;
  logic        cnt_valid;
  logic [1:0]  bus_trans = 2'b00;
  logic [31:0] bus_addr = '0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic        bus_ready, bus_resp;
  logic [31:0] bus_rdata;
  logic [CH-1:0] ovf;

  int tests = 0;
  int fails = 0;
  bit key_one_shot = 1'b0;
  bit win = 1'b0;
  int win_low = 0;

  always #5 clk = ~clk;

  cnt_acc dut (
    .main_clk_i(clk), .main_rst_i(rst),
    .key_valid_i(key_valid), .key_accept_o(key_accept),
    .key_data_i(key_data), .key_chan_i(key_chan),
    .cnt_o(cnt), .cnt_valid_o(cnt_valid),
    .bus_trans_i(bus_trans), .bus_addr_i(bus_addr),
    .bus_write_i(bus_write), .bus_wdata_i(bus_wdata),
    .bus_ready_o(bus_ready), .bus_resp_o(bus_resp), .bus_rdata_o(bus_rdata),
    .ovf_o(ovf)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: register contents as integers, stepped at each edge.
  bit          m_en, m_sat, m_clr, m_busy, m_err, m_cvalid;
  int          m_acc [CH];
  bit [CH-1:0] m_ovf;
  int          m_cnt;
  logic [31:0] m_rdata;

  always @(posedge clk) begin : model
    bit xfer, cap, wr, clr_n;
    int idx, pc, s, ch;
    bit [CH-1:0] ovf_n;
    int acc_n [CH];
    if (rst) begin
      m_en = 0; m_sat = 0; m_clr = 0; m_busy = 0; m_err = 0; m_cvalid = 0;
      m_ovf = '0; m_cnt = 0; m_rdata = '0;
      foreach (m_acc[i]) m_acc[i] = 0;
    end else begin
      xfer  = key_valid && m_en && !m_clr;
      cap   = !m_busy && bus_trans == 2'b10;
      wr    = cap && bus_write;
      pc    = $countones(key_data);
      ch    = int'(key_chan);
      ovf_n = m_ovf;
      acc_n = m_acc;
      clr_n = 0;
      idx   = -1;
      if (bus_addr >= 32'h10 && bus_addr < 32'h10 + 4 * CH && bus_addr % 4 == 0)
        idx = int'((bus_addr - 32'h10) / 4);
      if (cap) begin
        m_err   = !(bus_addr == 0 || bus_addr == 4 || idx >= 0);
        m_rdata = 0;
        if (!bus_write && !m_err) begin
          if (bus_addr == 0)      m_rdata = {30'd0, m_sat, m_en};
          else if (bus_addr == 4) m_rdata = 32'(m_ovf);
          else                    m_rdata = 32'(m_acc[idx]);
        end
      end
      if (wr && bus_addr == 4) ovf_n = ovf_n & ~bus_wdata[CH-1:0];
      if (xfer && ch < CH && !(wr && idx == ch)) begin
        s = m_acc[ch] + pc;
        if (s > 65535) begin
          ovf_n[ch] = 1;
          s = m_sat ? 65535 : s - 65536;
        end
        acc_n[ch] = s;
      end
      if (wr && idx >= 0) acc_n[idx] = int'(bus_wdata & 32'hFFFF);
      if (m_clr) begin
        ovf_n = '0;
        foreach (acc_n[i]) acc_n[i] = 0;
      end
      if (wr && bus_addr == 0) begin
        m_en = bus_wdata[0]; m_sat = bus_wdata[1]; clr_n = bus_wdata[2];
      end
      m_clr = clr_n; m_acc = acc_n; m_ovf = ovf_n;
      m_cvalid = xfer;
      if (xfer) m_cnt = pc;
      m_busy = cap;
    end
  end

  always @(negedge clk) begin
    chk("accept", key_accept, m_en && !m_clr);
    chk("cnt_valid", cnt_valid, m_cvalid);
    if (m_cvalid) chk("cnt", cnt, m_cnt);
    chk("ovf", ovf, m_ovf);
    chk("ready", bus_ready, m_busy);
    chk("resp", bus_resp, m_busy && m_err);
    chk("rdata", bus_rdata, m_busy ? m_rdata : 32'd0);
    if (win && !key_accept) win_low++;
  end

  task automatic bus_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    int n;
    bus_trans = 2'b10; bus_addr = addr; bus_write = wr; bus_wdata = wdata;
    @(posedge clk); #1;
    bus_trans = 2'b00;
    if (key_one_shot) begin key_valid = 0; key_one_shot = 0; end
    n = 0;
    while (!bus_ready && n < 8) begin @(posedge clk); #1; n++; end
    if (!bus_ready) begin
      tests++; fails++;
      $display("FAIL bus_timeout: no ready for addr 0x%0h", addr);
    end
    rdata = bus_rdata; err = bus_resp;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d; logic e;
    bus_xfer(1, addr, data, d, e);
    chk("wr_resp", e, 0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; logic e;
    bus_xfer(0, addr, 0, d, e);
    chk(name, d, exp);
    chk({name, "_resp"}, e, 0);
  endtask

  task automatic send(input logic [1:0] ch, input logic [9:0] data);
    key_valid = 1; key_chan = ch; key_data = data;
    @(posedge clk); #1;
    key_valid = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] d;
    logic e;
    int pulses;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus_ready, 0);
    chk("rst_cnt_valid", cnt_valid, 0);
    chk("rst_accept", key_accept, 0);
    rst = 0;
    rd_chk("rst_ctrl", 32'h00, 0);
    rd_chk("rst_acc2", 32'h18, 0);

    // Full-width sample on channel 2
    wr(32'h00, 32'h1);
    send(2, 10'h3FF);
    chk("pop_valid", cnt_valid, 1);
    chk("pop_cnt", cnt, 10);
    rd_chk("acc2", 32'h18, 32'h0000_000A);

    // Wrap mode
    wr(32'h14, 32'hFFFC);
    send(1, 10'h01F);
    rd_chk("acc1_wrap", 32'h14, 32'h0001);
    chk("ovf1_wrap", ovf[1], 1);
    rd_chk("status_wrap", 32'h04, 32'h2);
    wr(32'h04, 32'h2);
    chk("w1c", ovf, 0);

    // Saturating mode, overflow and exact-max
    wr(32'h00, 32'h3);
    wr(32'h14, 32'hFFFC);
    send(1, 10'h01F);
    rd_chk("acc1_sat", 32'h14, 32'hFFFF);
    chk("ovf1_sat", ovf[1], 1);
    wr(32'h04, 32'hF);
    wr(32'h14, 32'hFFFB);
    send(1, 10'h00F);
    rd_chk("acc1_max", 32'h14, 32'hFFFF);
    chk("ovf1_max", ovf[1], 0);

    // W1C colliding with a new overflow on the same channel
    wr(32'h00, 32'h1);
    wr(32'h14, 32'hFFFF);
    key_valid = 1; key_chan = 1; key_data = 10'h001; key_one_shot = 1;
    wr(32'h04, 32'h2);
    chk("w1c_vs_ovf", ovf[1], 1);
    rd_chk("acc1_wrap0", 32'h14, 0);

    // Bus write beats a simultaneous stream update
    key_valid = 1; key_chan = 3; key_data = 10'h3FF; key_one_shot = 1;
    wr(32'h1C, 32'h55);
    rd_chk("acc3_wr_wins", 32'h1C, 32'h55);

    // Clear pulse under continuous streaming
    key_valid = 1; key_chan = 0; key_data = 10'h001;
    repeat (3) @(posedge clk);
    #1;
    win = 1;
    wr(32'h00, 32'h5);
    chk("accept_resume", key_accept, 1);
    @(posedge clk); #1;
    key_valid = 0;
    @(posedge clk); #1;
    win = 0;
    chk("clr_low_cycles", win_low, 1);
    rd_chk("clr_ctrl", 32'h00, 32'h1);
    rd_chk("clr_acc0", 32'h10, 1);
    rd_chk("clr_acc1", 32'h14, 0);
    rd_chk("clr_acc2", 32'h18, 0);
    rd_chk("clr_acc3", 32'h1C, 0);
    rd_chk("clr_status", 32'h04, 0);

    // Error responses and ignored request during RESP
    bus_xfer(0, 32'h08, 0, d, e);
    chk("unmapped_resp", e, 1);
    chk("unmapped_rdata", d, 0);
    bus_xfer(1, 32'h05, 32'h3, d, e);
    chk("unaligned_resp", e, 1);
    rd_chk("unaligned_nochg", 32'h00, 32'h1);
    pulses = 0;
    bus_trans = 2'b10; bus_addr = 32'h00; bus_write = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus_trans = 2'b00;
      pulses += int'(bus_ready);
    end
    chk("one_ready_pulse", pulses, 1);

    // Reset while a response is pending and a sample is in flight
    bus_trans = 2'b10; bus_addr = 32'h00; bus_write = 0;
    key_valid = 1; key_chan = 0; key_data = 10'h3FF;
    @(posedge clk); #1;
    bus_trans = 2'b00; key_valid = 0;
    chk("resp_before_rst", bus_ready, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_drops_ready", bus_ready, 0);
    chk("rst_drops_valid", cnt_valid, 0);
    chk("rst_ovf", ovf, 0);
    rst = 0;
    rd_chk("post_rst_ctrl", 32'h00, 0);
    rd_chk("post_rst_status", 32'h04, 0);
    rd_chk("post_rst_acc0", 32'h10, 0);
    rd_chk("post_rst_acc3", 32'h1C, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
